// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter that funnels NREQ valid/ready producers into one registered output stage.
// Define RR_ARB_PKT_LOCK_EN to add req_last and hold the grant on one requester until its packet ends.
module rr_pipe_arbiter #(
   parameter  int WIDTH = 32,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef RR_ARB_PKT_LOCK_EN
   input  logic [NREQ-1:0]       req_last,
   output logic                  dbg_locked_o,
`endif
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic [IDW-1:0]        dbg_ptr_o,
   input  logic                  out_ready
);

   // Handshake: a beat moves on every posedge where valid and ready are both high;
   // ready may depend on valid, valid never depends on ready, and data is held until taken.

`ifdef RR_ARB_PKT_LOCK_EN
   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
   state_t         state_q;
   logic [IDW-1:0] owner_q;
`endif

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [IDW-1:0]   out_id_q;
   logic [IDW-1:0]   ptr_q;

   logic             load;
   logic             found;
   logic             accept;
   logic [IDW-1:0]   gnt_idx;
   logic [WIDTH-1:0] req_data_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_data_a[g] = req_data[g*WIDTH +: WIDTH];
   end

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
      return (i == IDW'(NREQ-1)) ? '0 : i + 1'b1;
   endfunction

   assign load = ~out_valid_q | out_ready;

   always_comb begin : p_grant
      logic [IDW-1:0] idx;
      idx     = '0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
`ifdef RR_ARB_PKT_LOCK_EN
      // The owner keeps the grant even while idle, so other requesters wait out its bubbles.
      if (state_q == ST_LOCKED) begin
         found   = req_valid[owner_q];
         gnt_idx = owner_q;
      end
`endif
   end

   assign accept    = found & load;
   assign req_ready = (accept && !rst) ? (NREQ'(1) << gnt_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
`ifdef RR_ARB_PKT_LOCK_EN
         state_q     <= ST_IDLE;
         owner_q     <= '0;
`endif
      end else begin
         if (load) begin
            out_valid_q <= accept;
            if (accept) begin
               out_data_q <= req_data_a[gnt_idx];
               out_id_q   <= gnt_idx;
            end
         end
`ifdef RR_ARB_PKT_LOCK_EN
         if (accept) begin
            case (state_q)
               ST_IDLE: begin
                  if (req_last[gnt_idx]) begin
                     ptr_q <= next_idx(gnt_idx);
                  end else begin
                     state_q <= ST_LOCKED;
                     owner_q <= gnt_idx;
                  end
               end
               ST_LOCKED: begin
                  if (req_last[owner_q]) begin
                     state_q <= ST_IDLE;
                     ptr_q   <= next_idx(owner_q);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
`else
         if (accept) begin
            ptr_q <= next_idx(gnt_idx);
         end
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign dbg_ptr_o = ptr_q;
`ifdef RR_ARB_PKT_LOCK_EN
   assign dbg_locked_o = (state_q == ST_LOCKED);
`endif

endmodule
